// File: rtl/dmem_pkg.sv
// Shared types and constants for the Y86-64 data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

  localparam int unsigned DefMemBytes = 1024;
  localparam int unsigned DefLatency  = 2;

  localparam logic [3:0] IcodeRmmovq = 4'h4;
  localparam logic [3:0] IcodeMrmovq = 4'h5;
  localparam logic [3:0] IcodeCall   = 4'h8;
  localparam logic [3:0] IcodeRet    = 4'h9;
  localparam logic [3:0] IcodePushq  = 4'hA;
  localparam logic [3:0] IcodePopq   = 4'hB;

  // The memory stage drives req_write from this.
  function automatic logic is_store(input logic [3:0] icode);
    return (icode == IcodeRmmovq) || (icode == IcodePushq) || (icode == IcodeCall);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-addressed storage with an 8-byte little-endian read port and write port; no reset.
module dmem_array import dmem_pkg::*; #(
  parameter int unsigned MEM_BYTES = DefMemBytes,
  parameter int unsigned AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [7:0] mem [MEM_BYTES];

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++) begin
      rdata[8*i +: 8] = mem[addr + AW'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        mem[addr + AW'(i)] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Latency-programmable data-memory responder: valid/ready request in, one response out per access.
module dmem_responder import dmem_pkg::*; #(
  parameter int unsigned MEM_BYTES = DefMemBytes,
  parameter int unsigned LATENCY   = DefLatency,
  parameter int unsigned CNT_W     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_error
);

  localparam int unsigned AW = $clog2(MEM_BYTES);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        addr_q, addr_d;
  logic [63:0]        wdata_q, wdata_d;
  logic               write_q, write_d;
  logic [63:0]        rdata_q, rdata_d;
  logic               error_q, error_d;

  logic [64:0]        end_addr;
  logic               range_err;
  logic               commit;
  logic               mem_we;
  logic [63:0]        mem_rdata;

  // 65-bit sum so addresses near 2^64 overflow into bit 64 instead of wrapping.
  assign end_addr  = {1'b0, addr_q} + 65'd8;
  assign range_err = end_addr > 65'(MEM_BYTES);
  assign commit    = (state_q == StBusy) && (cnt_q == '0);
  assign mem_we    = commit && write_q && !range_err;

  dmem_array #(
    .MEM_BYTES (MEM_BYTES),
    .AW        (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_q[AW-1:0]),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
    error_d = error_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StBusy;
          cnt_d   = CNT_W'(LATENCY);
          addr_d  = req_addr;
          wdata_d = req_wdata;
          write_d = req_write;
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d = StResp;
          error_d = range_err;
          rdata_d = (range_err || write_q) ? '0 : mem_rdata;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed and random accesses checked against a byte-array model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [63:0] req_addr  = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_ready = 1'b0;
  logic        req_ready, resp_valid, resp_error;
  logic [63:0] resp_rdata;

  logic        l_req_valid = 1'b0;
  logic        l_resp_ready = 1'b0;
  logic [63:0] l_addr = 64'h10;
  logic        l0_req_ready, l0_resp_valid, l0_resp_error;
  logic        l5_req_ready, l5_resp_valid, l5_resp_error;
  logic [63:0] l0_resp_rdata, l5_resp_rdata;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  mdl [1024];
  logic [63:0] last_rdata;

  always #5 clk = ~clk;

  dmem_responder #(.MEM_BYTES(1024), .LATENCY(2), .CNT_W(4)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error)
  );

  dmem_responder #(.MEM_BYTES(1024), .LATENCY(0), .CNT_W(4)) u_lat0 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (l_req_valid),
    .req_write  (1'b0),
    .req_addr   (l_addr),
    .req_wdata  (64'h0),
    .req_ready  (l0_req_ready),
    .resp_valid (l0_resp_valid),
    .resp_ready (l_resp_ready),
    .resp_rdata (l0_resp_rdata),
    .resp_error (l0_resp_error)
  );

  dmem_responder #(.MEM_BYTES(1024), .LATENCY(5), .CNT_W(4)) u_lat5 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (l_req_valid),
    .req_write  (1'b0),
    .req_addr   (l_addr),
    .req_wdata  (64'h0),
    .req_ready  (l5_req_ready),
    .resp_valid (l5_resp_valid),
    .resp_ready (l_resp_ready),
    .resp_rdata (l5_resp_rdata),
    .resp_error (l5_resp_error)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full access; the model is updated from the address rules, not from the DUT.
  task automatic do_txn(input string tag, input logic wr, input logic [63:0] addr,
                        input logic [63:0] wd, input int hold, input logic pend);
    logic        err;
    logic [63:0] exp;
    int          n;
    err = ({1'b0, addr} + 65'd8) > 65'd1024;
    exp = '0;
    if (!err && !wr) for (int i = 0; i < 8; i++) exp[8*i +: 8] = mdl[int'(addr) + i];
    if (!err && wr)  for (int i = 0; i < 8; i++) mdl[int'(addr) + i] = wd[8*i +: 8];
    check({tag, " req_ready idle"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    // Scramble inputs to prove they were latched at accept.
    req_valid = 1'b0; req_write = ~wr; req_addr = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    n = 0;
    while (!resp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'd3);
    check({tag, " rdata"}, resp_rdata, exp);
    check({tag, " error"}, 64'(resp_error), 64'(err));
    last_rdata = resp_rdata;
    if (pend) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h8;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, " hold valid"}, 64'(resp_valid), 64'd1);
      check({tag, " hold rdata"}, resp_rdata, exp);
      check({tag, " hold req_ready"}, 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    check({tag, " valid drop"}, 64'(resp_valid), 64'd0);
    check({tag, " req_ready back"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    int n0, n5, r, hold;
    logic [63:0] a;
    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", 64'(req_ready), 64'd1);
    check("reset resp_valid", 64'(resp_valid), 64'd0);
    check("reset rdata", resp_rdata, 64'd0);
    check("reset error", 64'(resp_error), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Latency parameter: LATENCY=0 and LATENCY=5 instances accept on the same edge.
    l_req_valid = 1'b1;
    @(posedge clk); #1;
    l_req_valid = 1'b0;
    n0 = 0; n5 = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (n0 == 0 && l0_resp_valid) n0 = k;
      if (n5 == 0 && l5_resp_valid) n5 = k;
    end
    check("lat0 edges", 64'(n0), 64'd1);
    check("lat5 edges", 64'(n5), 64'd6);
    l_resp_ready = 1'b1;
    @(posedge clk); #1;
    l_resp_ready = 1'b0;
    check("lat0 drop", 64'(l0_resp_valid), 64'd0);
    check("lat5 drop", 64'(l5_resp_valid), 64'd0);

    for (int b = 0; b < 1024; b += 8) do_txn("init", 1'b1, 64'(b), {$urandom, $urandom}, 0, 1'b0);

    do_txn("st 2ff", 1'b1, 64'h2FF, 64'h48E9230AF28C4B74, 0, 1'b0);
    do_txn("ld 2ff", 1'b0, 64'h2FF, 64'h0, 0, 1'b0);
    check("ld 2ff const", last_rdata, 64'h48E9230AF28C4B74);
    do_txn("zero 36c", 1'b1, 64'h36C, 64'h0, 0, 1'b0);
    do_txn("call st 374", 1'b1, 64'h374, 64'h9463197C93D8910A, 0, 1'b0);
    do_txn("ld 374", 1'b0, 64'h374, 64'h0, 0, 1'b0);
    check("ld 374 const", last_rdata, 64'h9463197C93D8910A);
    do_txn("ld 370", 1'b0, 64'h370, 64'h0, 0, 1'b0);
    check("ld 370 const", last_rdata, 64'h93D8910A00000000);

    do_txn("ld 3f8", 1'b0, 64'h3F8, 64'h0, 0, 1'b0);
    do_txn("st 3f9 err", 1'b1, 64'h3F9, 64'hDEADBEEFCAFEF00D, 0, 1'b0);
    do_txn("ld 3f8 unchanged", 1'b0, 64'h3F8, 64'h0, 0, 1'b0);
    do_txn("ld 3f9 err", 1'b0, 64'h3F9, 64'h0, 0, 1'b0);
    do_txn("st big err", 1'b1, 64'h0941858AC02818FF, 64'h1, 0, 1'b0);
    do_txn("ld nowrap err", 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'h0, 0, 1'b0);
    do_txn("st nowrap err", 1'b1, 64'hFFFFFFFFFFFFFFFC, 64'h5, 0, 1'b0);
    do_txn("ld 000 after nowrap", 1'b0, 64'h0, 64'h0, 0, 1'b0);

    do_txn("backpressure", 1'b0, 64'h2FF, 64'h0, 5, 1'b1);

    // Reset abort: store in flight is dropped; model is left unchanged.
    do_txn("pre-abort ld", 1'b0, 64'h100, 64'h0, 0, 1'b0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h100; req_wdata = 64'h1122334455667788;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("abort busy", 64'(req_ready), 64'd0);
    rst = 1'b1;
    #1;
    check("abort req_ready", 64'(req_ready), 64'd1);
    check("abort resp_valid", 64'(resp_valid), 64'd0);
    check("abort rdata", resp_rdata, 64'd0);
    check("abort error", 64'(resp_error), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_txn("post-abort ld", 1'b0, 64'h100, 64'h0, 0, 1'b0);

    for (int t = 0; t < 200; t++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       a = 64'($urandom_range(0, 1023));
      else if (r < 8)  a = 64'($urandom_range(1010, 1023));
      else if (r == 8) a = {$urandom, $urandom};
      else             a = 64'hFFFFFFFFFFFFFFF8 + 64'($urandom_range(0, 7));
      hold = $urandom_range(0, 2);
      do_txn("rand", 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, hold,
             1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the sequential Y86-64 memory stage's 8-byte load/store requests.
- The memory stage decides read/write/address/data from icode, valA and valE. This block accepts the request over a valid/ready handshake, waits a programmable latency, commits the access, then returns valM data and a dmem_error status.
- Replaces the zero-latency internal array so that stall behaviour can be exercised.

Parameters:
- MEM_BYTES, 1024, size of byte-addressed storage.
- LATENCY, 2, extra wait cycles between request acceptance and commit (0..15).
- CNT_W, 4, width of the latency counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_write  input  1  1 = store (rmmovq/pushq/call), 0 = load (mrmovq/popq/ret).
- req_addr  input  64  byte address (valE, or valA for popq/ret).
- req_wdata  input  64  store data (valA, or valP for call).
- req_ready  output  1  block can accept a request.
- resp_valid  output  1  response present.
- resp_ready  input  1  memory stage consumes response.
- resp_rdata  output  64  load data (valM); 0 for stores and errors.
- resp_error  output  1  dmem_error for this access.

Behaviour:
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, cnt=0. Storage contents are not cleared by reset.
- Request capture:
  - A request is accepted on a rising edge where req_valid && req_ready.
  - addr, write and wdata are latched at that edge; later input changes are ignored.
- FSM states:
  - IDLE: req_ready=1. On accept, go to BUSY with cnt=LATENCY.
  - BUSY: req_ready=0. If cnt==0, commit the access and go to RESP; else cnt=cnt-1.
  - RESP: resp_valid=1 and outputs are held stable. On resp_ready, go to IDLE. The next request cannot be accepted in the same cycle; req_ready rises the following cycle.
- Latency: resp_valid rises after exactly LATENCY+1 rising edges following the accept edge. LATENCY=0 gives 1 cycle.
- Range check:
  - error = (addr + 8) > MEM_BYTES, evaluated in 65-bit arithmetic.
  - Addresses near 2^64 must flag an error, never wrap.
- Error access: no storage modified; resp_rdata=0; resp_error=1.
- Store commit: bytes addr..addr+7 are written little-endian (wdata[7:0] at addr); resp_rdata=0; resp_error=0.
- Load commit: resp_rdata = {mem[addr+7],...,mem[addr]}; resp_error=0.
- Alignment: unaligned addresses are legal, with no alignment error.
- Simultaneity: a load issued after a store to the same bytes returns the new data, because commits are serialised.
- Reset mid-operation: reset asserted in BUSY before the commit edge aborts the access; the store is not performed and no response is produced. Reset in RESP drops the response.
- A req_valid held high through BUSY/RESP is not accepted until IDLE.

Decomposition:
- Package dmem_pkg:
  - state encoding (IDLE, BUSY, RESP);
  - default MEM_BYTES/LATENCY;
  - Y86 icode constants (IRMMOVQ=4, IMRMOVQ=5, ICALL=8, IRET=9, IPUSHQ=A, IPOPQ=B) used by the memory stage to drive req_write.
- Sub-module dmem_array: byte array with 8-byte little-endian read port and write port with write enable. No reset.
- The FSM, counter and range check live in dmem_responder.

Test Plan:
- Store then load: write 0x2FF with 0x48E9230AF28C4B74 (resp_rdata 0, error 0 at accept+3), then load 0x2FF -> resp_rdata 0x48E9230AF28C4B74, error 0, 3 cycles after accept.
- Call-style store: write 0x374 with 0x9463197C93D8910A, then load 0x374 -> same value. Load 0x370 -> 0x93D8910A00000000 lower word pattern confirming little-endian byte placement, with bytes 0x370..0x373 previously 0.
- Range boundary:
  - 0x3F8 -> error 0.
  - 0x3F9 -> error 1, rdata 0, memory unchanged.
  - 0x0941858AC02818FF -> error 1.
  - 0xFFFFFFFFFFFFFFFC -> error 1 (no wrap).
- Backpressure: hold resp_ready=0 for 5 cycles. resp_valid and rdata stay stable, req_ready stays 0, and a second req_valid is not accepted until one cycle after resp_ready.
- Reset abort: store 0x100 with 0x1122334455667788, assert rst during BUSY (cnt=1). Outputs return to reset values; after release, load 0x100 returns the old contents.
- Latency parameter: with LATENCY=0, resp_valid rises 1 edge after accept. With LATENCY=5, it rises after 6 edges.
